normalise_product_y: RTL and testbench

NORMALISE_PRODUCT_Y -- requirements
Module: normalise_product_y

---
 rtl/normalise_product_y.sv | 201 ++++++++++++++++++++
 tb/tb_normalise_product_y.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalise_product_y.sv
// normalise_product_y
// Normalises and rounds the unsigned mantissa product from the multiply stage.
// The product is shifted left one bit per cycle until bit 49 is set (the
// exponent is decremented with each shift). It is then rounded to 27 bits,
// round-to-nearest-even, and packed as {sign, exponent, mantissa}. Operands
// whose idle code is not no_idle are passed through unchanged.
//
// Ports
//   clock, reset_n            : clock, synchronous active-low reset
//   in_valid / in_ready       : input handshake (ready only in IDLE)
//   productout_Multiply[49:0] : unsigned mantissa product
//   zout_Multiply[35:0]       : {sign, exponent[7:0], mantissa[26:0]}
//   *_Multiply sidebands      : idle, cout, sout, mode, operation, NatLogFlag, InsTag
//   out_valid / out_ready     : output handshake (valid only in DONE)
//   zout_Normalise[35:0]      : packed normalised result
//   *_Normalise sidebands     : registered copies of the accepted sidebands
module normalise_product_y #(
  parameter logic [1:0] no_idle         = 2'b00,
  parameter logic [1:0] mode_circular   = 2'b01,
  parameter logic [1:0] mode_linear     = 2'b00,
  parameter logic [1:0] mode_hyperbolic = 2'b11
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [49:0] productout_Multiply,
  input  logic [35:0] zout_Multiply,
  input  logic [1:0]  idle_Multiply,
  input  logic [35:0] cout_Multiply,
  input  logic [31:0] sout_Multiply,
  input  logic [1:0]  modeout_Multiply,
  input  logic        operationout_Multiply,
  input  logic        NatLogFlagout_Multiply,
  input  logic [7:0]  InsTag_Multiply,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] zout_Normalise,
  output logic [1:0]  idle_Normalise,
  output logic [35:0] cout_Normalise,
  output logic [31:0] sout_Normalise,
  output logic [1:0]  modeout_Normalise,
  output logic        operationout_Normalise,
  output logic        NatLogFlagout_Normalise,
  output logic [7:0]  InsTag_Normalise
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [49:0] r_work;
  logic        r_sign;
  logic [7:0]  r_exp;
  logic [35:0] r_zout;
  logic [1:0]  r_idle;
  logic [35:0] r_cout;
  logic [31:0] r_sout;
  logic [1:0]  r_mode;
  logic        r_op;
  logic        r_natlog;
  logic [7:0]  r_tag;

  logic        w_accept;
  logic        w_work_zero;
  logic        w_shift_done;
  logic [26:0] w_m;
  logic        w_g;
  logic        w_s;
  logic        w_inc;
  logic [35:0] w_round_z;
  logic [1:0]  w_mode_code;

  assign w_accept     = in_valid && in_ready;
  assign w_work_zero  = (r_work == '0);
  assign w_shift_done = w_work_zero || r_work[49];

  // Rounding fields taken from the normalised working register
  assign w_m   = r_work[49:23];
  assign w_g   = r_work[22];
  assign w_s   = |r_work[21:0];
  assign w_inc = w_g && (w_s || w_m[0]);

  always_comb begin
    w_round_z = {r_sign, r_exp, w_m};
    if (w_work_zero) begin
      w_round_z = {r_sign, 8'h00, 27'h0};
    end else if (w_inc && (&w_m)) begin
      // Mantissa carry-out renormalises to 1.000... with exponent + 1
      w_round_z = {r_sign, r_exp + 8'd1, 27'h4000000};
    end else begin
      w_round_z = {r_sign, r_exp, w_m + {26'h0, w_inc}};
    end
  end

  // Mode codes are forwarded unchanged; recognised codes map onto themselves
  always_comb begin
    w_mode_code = modeout_Multiply;
    case (modeout_Multiply)
      mode_circular:   w_mode_code = mode_circular;
      mode_linear:     w_mode_code = mode_linear;
      mode_hyperbolic: w_mode_code = mode_hyperbolic;
      default:         w_mode_code = modeout_Multiply;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (idle_Multiply == no_idle) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (w_shift_done) begin
          w_state_next = ROUND;
        end
      end
      ROUND: begin
        w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_work   <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_zout   <= '0;
      r_idle   <= '0;
      r_cout   <= '0;
      r_sout   <= '0;
      r_mode   <= '0;
      r_op     <= 1'b0;
      r_natlog <= 1'b0;
      r_tag    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work   <= productout_Multiply;
            r_sign   <= zout_Multiply[35];
            r_exp    <= zout_Multiply[34:27];
            r_idle   <= idle_Multiply;
            r_cout   <= cout_Multiply;
            r_sout   <= sout_Multiply;
            r_mode   <= w_mode_code;
            r_op     <= operationout_Multiply;
            r_natlog <= NatLogFlagout_Multiply;
            r_tag    <= InsTag_Multiply;
            if (idle_Multiply != no_idle) begin
              r_zout <= zout_Multiply;
            end
          end
        end
        SHIFT: begin
          if (!w_shift_done) begin
            r_work <= {r_work[48:0], 1'b0};
            r_exp  <= r_exp - 8'd1;
          end
        end
        ROUND: begin
          r_zout <= w_round_z;
        end
        default: begin
        end
      endcase
    end
  end

  assign zout_Normalise          = r_zout;
  assign idle_Normalise          = r_idle;
  assign cout_Normalise          = r_cout;
  assign sout_Normalise          = r_sout;
  assign modeout_Normalise       = r_mode;
  assign operationout_Normalise  = r_op;
  assign NatLogFlagout_Normalise = r_natlog;
  assign InsTag_Normalise        = r_tag;

endmodule

// File: tb/tb_normalise_product_y.sv
// Directed testbench for normalise_product_y.
// Latency below is the number of rising edges after the accept edge until
// out_valid is seen high; a bypass result is visible right after the accept edge.
module tb_normalise_product_y;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] productout_Multiply;
  logic [35:0] zout_Multiply;
  logic [1:0]  idle_Multiply;
  logic [35:0] cout_Multiply;
  logic [31:0] sout_Multiply;
  logic [1:0]  modeout_Multiply;
  logic        operationout_Multiply;
  logic        NatLogFlagout_Multiply;
  logic [7:0]  InsTag_Multiply;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] zout_Normalise;
  logic [1:0]  idle_Normalise;
  logic [35:0] cout_Normalise;
  logic [31:0] sout_Normalise;
  logic [1:0]  modeout_Normalise;
  logic        operationout_Normalise;
  logic        NatLogFlagout_Normalise;
  logic [7:0]  InsTag_Normalise;

  int n_checks = 0;
  int n_fail   = 0;

  normalise_product_y #(
    .no_idle        (2'b00),
    .mode_circular  (2'b01),
    .mode_linear    (2'b00),
    .mode_hyperbolic(2'b11)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .productout_Multiply    (productout_Multiply),
    .zout_Multiply          (zout_Multiply),
    .idle_Multiply          (idle_Multiply),
    .cout_Multiply          (cout_Multiply),
    .sout_Multiply          (sout_Multiply),
    .modeout_Multiply       (modeout_Multiply),
    .operationout_Multiply  (operationout_Multiply),
    .NatLogFlagout_Multiply (NatLogFlagout_Multiply),
    .InsTag_Multiply        (InsTag_Multiply),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .zout_Normalise         (zout_Normalise),
    .idle_Normalise         (idle_Normalise),
    .cout_Normalise         (cout_Normalise),
    .sout_Normalise         (sout_Normalise),
    .modeout_Normalise      (modeout_Normalise),
    .operationout_Normalise (operationout_Normalise),
    .NatLogFlagout_Normalise(NatLogFlagout_Normalise),
    .InsTag_Normalise       (InsTag_Normalise)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one operand through the accept edge and waits (bounded) for out_valid.
  // lat = -1 when out_valid never rose within the budget.
  task automatic run_txn(input logic [49:0] p, input logic [35:0] z,
                         input logic [1:0] idle, input logic [7:0] tag,
                         output int lat);
    @(negedge clock);
    productout_Multiply = p;
    zout_Multiply       = z;
    idle_Multiply       = idle;
    InsTag_Multiply     = tag;
    in_valid            = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (zout_Normalise !== 36'h0) begin n_fail++; $display("FAIL reset_zout got=%h exp=0", zout_Normalise); end
    n_checks++;
    if ({idle_Normalise, cout_Normalise, sout_Normalise, modeout_Normalise,
         operationout_Normalise, NatLogFlagout_Normalise, InsTag_Normalise} !== '0) begin
      n_fail++;
      $display("FAIL reset_sidebands got=%h/%h/%h/%h/%b/%b/%h exp=0", idle_Normalise, cout_Normalise,
               sout_Normalise, modeout_Normalise, operationout_Normalise, NatLogFlagout_Normalise, InsTag_Normalise);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_shift_one();
    int lat;
    run_txn(50'h1000000000000, {1'b0, 8'h01, 27'h0}, 2'b00, 8'h01, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL shift1_latency got=%0d exp=3", lat); end
    n_checks++;
    if (zout_Normalise !== {1'b0, 8'h00, 27'h4000000}) begin
      n_fail++; $display("FAIL shift1_zout got=%h exp=%h", zout_Normalise, {1'b0, 8'h00, 27'h4000000});
    end
    release_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL shift1_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_round_overflow();
    int lat;
    run_txn(50'h3FFFFFFFFFFFF, {1'b0, 8'h05, 27'h0}, 2'b00, 8'h02, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
    n_checks++;
    if (zout_Normalise !== {1'b0, 8'h06, 27'h4000000}) begin
      n_fail++; $display("FAIL ovf_zout got=%h exp=%h", zout_Normalise, {1'b0, 8'h06, 27'h4000000});
    end
    release_result();
  endtask

  task automatic test_rounding_ties();
    int lat;
    // Tie with even LSB: no increment
    run_txn(50'h2000000400000, {1'b1, 8'h10, 27'h0}, 2'b00, 8'h03, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL tie_even_latency got=%0d exp=2", lat); end
    n_checks++;
    if (zout_Normalise !== {1'b1, 8'h10, 27'h4000000}) begin
      n_fail++; $display("FAIL tie_even_zout got=%h exp=%h", zout_Normalise, {1'b1, 8'h10, 27'h4000000});
    end
    release_result();
    // Tie with odd LSB: round up to even
    run_txn(50'h2000000C00000, {1'b0, 8'h20, 27'h0}, 2'b00, 8'h04, lat);
    n_checks++;
    if (zout_Normalise !== {1'b0, 8'h20, 27'h4000002}) begin
      n_fail++; $display("FAIL tie_odd_zout got=%h exp=%h", zout_Normalise, {1'b0, 8'h20, 27'h4000002});
    end
    release_result();
  endtask

  task automatic test_exponent_wrap();
    int lat;
    // k = 2, exponent 01 -> FF (modulo 256)
    run_txn(50'h0800000000000, {1'b0, 8'h01, 27'h0}, 2'b00, 8'h05, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    n_checks++;
    if (zout_Normalise !== {1'b0, 8'hFF, 27'h4000000}) begin
      n_fail++; $display("FAIL wrap_zout got=%h exp=%h", zout_Normalise, {1'b0, 8'hFF, 27'h4000000});
    end
    release_result();
    // k = 49, maximum shift count
    run_txn(50'h1, {1'b0, 8'h40, 27'h0}, 2'b00, 8'h06, lat);
    n_checks++;
    if (lat !== 51) begin n_fail++; $display("FAIL k49_latency got=%0d exp=51", lat); end
    n_checks++;
    if (zout_Normalise !== {1'b0, 8'h0F, 27'h4000000}) begin
      n_fail++; $display("FAIL k49_zout got=%h exp=%h", zout_Normalise, {1'b0, 8'h0F, 27'h4000000});
    end
    release_result();
  endtask

  task automatic test_zero();
    int lat;
    run_txn(50'h0, {1'b1, 8'h33, 27'h1234}, 2'b00, 8'h07, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    n_checks++;
    if (zout_Normalise !== 36'h800000000) begin
      n_fail++; $display("FAIL zero_zout got=%h exp=800000000", zout_Normalise);
    end
    release_result();
  endtask

  task automatic test_bypass();
    int lat;
    cout_Multiply          = 36'h123456789;
    sout_Multiply          = 32'hDEADBEEF;
    modeout_Multiply       = 2'b11;
    operationout_Multiply  = 1'b1;
    NatLogFlagout_Multiply = 1'b1;
    run_txn(50'h155555, 36'hABCDEF012, 2'b01, 8'h5A, lat);
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL bypass_latency got=%0d exp=0", lat); end
    n_checks++;
    if (zout_Normalise !== 36'hABCDEF012) begin
      n_fail++; $display("FAIL bypass_zout got=%h exp=abcdef012", zout_Normalise);
    end
    n_checks++;
    if (InsTag_Normalise !== 8'h5A || idle_Normalise !== 2'b01 || cout_Normalise !== 36'h123456789 ||
        sout_Normalise !== 32'hDEADBEEF || modeout_Normalise !== 2'b11 ||
        operationout_Normalise !== 1'b1 || NatLogFlagout_Normalise !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_sidebands got=%h/%h/%h/%h/%h/%b/%b exp=5a/1/123456789/deadbeef/3/1/1",
               InsTag_Normalise, idle_Normalise, cout_Normalise, sout_Normalise,
               modeout_Normalise, operationout_Normalise, NatLogFlagout_Normalise);
    end
    release_result();
    cout_Multiply          = '0;
    sout_Multiply          = '0;
    modeout_Multiply       = 2'b00;
    operationout_Multiply  = 1'b0;
    NatLogFlagout_Multiply = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_txn(50'h2000000000000, {1'b0, 8'h22, 27'h0}, 2'b00, 8'h11, lat);
    // Competing operand presented throughout DONE
    productout_Multiply = 50'h0;
    zout_Multiply       = 36'hFFFFFFFFF;
    idle_Multiply       = 2'b01;
    InsTag_Multiply     = 8'hEE;
    in_valid            = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          zout_Normalise !== {1'b0, 8'h22, 27'h4000000} || InsTag_Normalise !== 8'h11) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL hold_stable got=%0d unstable cycles (last zout=%h tag=%h valid=%b) exp=0",
                         bad, zout_Normalise, InsTag_Normalise, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    n_checks++;
    if (InsTag_Normalise !== 8'h11 || zout_Normalise !== {1'b0, 8'h22, 27'h4000000}) begin
      n_fail++; $display("FAIL no_accept_in_done got tag=%h zout=%h exp tag=11 zout=%h",
                         InsTag_Normalise, zout_Normalise, {1'b0, 8'h22, 27'h4000000});
    end
    idle_Multiply = 2'b00;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clock);
    productout_Multiply = 50'h1;
    zout_Multiply       = {1'b0, 8'h40, 27'h0};
    idle_Multiply       = 2'b00;
    InsTag_Multiply     = 8'h77;
    in_valid            = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midshift_reset got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    n_checks++;
    if (zout_Normalise !== 36'h0 || InsTag_Normalise !== 8'h00) begin
      n_fail++; $display("FAIL midshift_reset_data got zout=%h tag=%h exp 0/0", zout_Normalise, InsTag_Normalise);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midshift_discard got=%0d valid cycles exp=0", seen); end
  endtask

  initial begin
    reset_n                = 1'b0;
    in_valid               = 1'b0;
    out_ready              = 1'b0;
    productout_Multiply    = '0;
    zout_Multiply          = '0;
    idle_Multiply          = 2'b00;
    cout_Multiply          = '0;
    sout_Multiply          = '0;
    modeout_Multiply       = 2'b00;
    operationout_Multiply  = 1'b0;
    NatLogFlagout_Multiply = 1'b0;
    InsTag_Multiply        = '0;
    test_reset();
    test_shift_one();
    test_round_overflow();
    test_rounding_ties();
    test_exponent_wrap();
    test_zero();
    test_bypass();
    test_backpressure();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
